// File: rtl/pipeline_hazard_control_unit_if.sv
// rtl/pipeline_hazard_control_unit_if.sv - hazard unit signal bundle between pipeline datapath and controller
interface pipeline_hazard_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ID_Rs1;
  logic [4:0]       ID_Rs2;
  logic             ID_uses_rs1;
  logic             ID_uses_rs2;
  logic             EX_MemRead;
  logic [4:0]       EX_Rd;
  logic             EX_branch_taken;
  logic             MEM_req;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_Rs1, ID_Rs2, ID_uses_rs1, ID_uses_rs2, EX_MemRead, EX_Rd,
           EX_branch_taken, MEM_req, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_flush, mem_timeout, stall_count, flush_count
  );

  modport slave (
    input  ID_Rs1, ID_Rs2, ID_uses_rs1, ID_uses_rs2, EX_MemRead, EX_Rd,
           EX_branch_taken, MEM_req, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_flush, mem_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_control_unit.sv
// rtl/pipeline_hazard_control_unit.sv - stall/flush controller for load-use, taken branch and dmem wait
module pipeline_hazard_control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_control_unit_if.slave hz
);
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  state_t           state;
  logic [WAIT_W-1:0] wait_cnt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic mem_wait;
  logic lu;
  logic freeze;
  logic take_branch;
  logic load_use;
  logic pc_en;

  assign mem_wait = hz.MEM_req & ~hz.dmem_ready;
  assign lu = hz.EX_MemRead & (hz.EX_Rd != 5'd0) &
              ((hz.ID_uses_rs1 & (hz.ID_Rs1 == hz.EX_Rd)) |
               (hz.ID_uses_rs2 & (hz.ID_Rs2 == hz.EX_Rd)));

  // Priority: freeze > taken branch > load-use; a branch wins over load-use
  // because the dependent ID instruction is being discarded anyway.
  assign freeze      = (state == FAULT) | mem_wait;
  assign take_branch = ~freeze & hz.EX_branch_taken;
  assign load_use    = ~freeze & ~hz.EX_branch_taken & lu;
  assign pc_en       = ~freeze & ~load_use;

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = pc_en;
  assign hz.ifid_flush  = take_branch;
  assign hz.idex_en     = ~freeze;
  assign hz.idex_flush  = take_branch | load_use;
  assign hz.exmem_en    = ~freeze;
  assign hz.memwb_flush = freeze;
  assign hz.mem_timeout = timeout_q;
  assign hz.stall_count = stall_q;
  assign hz.flush_count = flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            state    <= MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_wait) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state     <= FAULT;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= RUN;
        end
      endcase

      if (!pc_en && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (take_branch && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_control_unit.sv
// tb/tb_pipeline_hazard_control_unit.sv - scoreboard bench for the pipeline hazard controller
module tb_pipeline_hazard_control_unit;
  localparam int MT = 4;
  localparam int CW = 4;

  // ctl order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_flush mem_timeout
  localparam logic [7:0] C_N = 8'b1101_0100;
  localparam logic [7:0] C_L = 8'b0001_1100;
  localparam logic [7:0] C_B = 8'b1111_1100;
  localparam logic [7:0] C_F = 8'b0000_0010;
  localparam logic [7:0] C_X = 8'b0000_0011;
  localparam logic [7:0] M_A = 8'hFF;
  localparam logic [7:0] M_T = 8'hFE;

  typedef struct {
    string      name;
    logic [7:0] ctl;
    logic [7:0] mask;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   ncmp;
  int   nfail;

  pipeline_hazard_control_unit_if #(.CNT_W(CW)) hz ();

  pipeline_hazard_control_unit #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input string nm, input logic rst,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic mr,
                      input logic [4:0] rd, input logic br,
                      input logic req, input logic rdy,
                      input logic [7:0] ctl, input logic [7:0] mask,
                      input logic [3:0] sc, input logic [3:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n              = rst;
    hz.ID_Rs1          = rs1;
    hz.ID_Rs2          = rs2;
    hz.ID_uses_rs1     = u1;
    hz.ID_uses_rs2     = u2;
    hz.EX_MemRead      = mr;
    hz.EX_Rd           = rd;
    hz.EX_branch_taken = br;
    hz.MEM_req         = req;
    hz.dmem_ready      = rdy;
    e.name = nm;
    e.ctl  = ctl;
    e.mask = mask;
    e.sc   = sc;
    e.fc   = fc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic rst, input logic [7:0] ctl,
                      input logic [3:0] sc, input logic [3:0] fc);
    step(nm, rst, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, ctl, M_A, sc, fc);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [7:0] act;
      e = exp_q.pop_front();
      act = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
             hz.exmem_en, hz.memwb_flush, hz.mem_timeout};
      ncmp++;
      if ((act & e.mask) !== (e.ctl & e.mask)) begin
        nfail++;
        $display("FAIL %s ctl: got %b want %b (mask %b)", e.name, act, e.ctl, e.mask);
      end
      ncmp++;
      if (hz.stall_count !== e.sc) begin
        nfail++;
        $display("FAIL %s stall_count: got %0d want %0d", e.name, hz.stall_count, e.sc);
      end
      ncmp++;
      if (hz.flush_count !== e.fc) begin
        nfail++;
        $display("FAIL %s flush_count: got %0d want %0d", e.name, hz.flush_count, e.fc);
      end
    end
  end

  initial begin
    ncmp  = 0;
    nfail = 0;
    rst_n              = 1'b0;
    hz.ID_Rs1          = 5'd0;
    hz.ID_Rs2          = 5'd0;
    hz.ID_uses_rs1     = 1'b0;
    hz.ID_uses_rs2     = 1'b0;
    hz.EX_MemRead      = 1'b0;
    hz.EX_Rd           = 5'd0;
    hz.EX_branch_taken = 1'b0;
    hz.MEM_req         = 1'b0;
    hz.dmem_ready      = 1'b1;

    // reset state and load-use detection
    idle("reset", 1'b0, C_N, 4'd0, 4'd0);
    idle("run_idle", 1'b1, C_N, 4'd0, 4'd0);
    step("lu_rs2", 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, C_L, M_A, 4'd0, 4'd0);
    idle("after_lu", 1'b1, C_N, 4'd1, 4'd0);
    step("lu_rd0", 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, C_N, M_A, 4'd1, 4'd0);
    step("lu_nouse", 1'b1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, C_N, M_A, 4'd1, 4'd0);
    step("lu_rs1", 1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, C_L, M_A, 4'd1, 4'd0);
    idle("after_lu_rs1", 1'b1, C_N, 4'd2, 4'd0);

    // taken branch overrides load-use
    idle("reset3", 1'b0, C_N, 4'd0, 4'd0);
    step("br_lu", 1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b1, C_B, M_A, 4'd0, 4'd0);
    idle("after_br", 1'b1, C_N, 4'd0, 4'd1);

    // branch held across a dmem wait
    idle("reset4", 1'b0, C_N, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      step("wait_br", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, C_F, M_A, 4'(i), 4'd0);
    end
    step("release_br", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, C_B, M_A, 4'd3, 4'd0);
    idle("after_release", 1'b1, C_N, 4'd3, 4'd1);

    // dmem timeout, sticky fault, async reset mid-wait
    idle("reset5", 1'b0, C_N, 4'd0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      step("tmo_wait", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0,
           (i == 5) ? C_X : C_F, (i == 3 || i == 4) ? M_T : M_A, 4'(i), 4'd0);
    end
    idle("fault_hold0", 1'b1, C_X, 4'd6, 4'd0);
    idle("fault_hold1", 1'b1, C_X, 4'd7, 4'd0);
    step("async_rst", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_F, M_A, 4'd0, 4'd0);

    // stall counter saturation
    for (int i = 0; i < 18; i++) begin
      step("sat", 1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, C_L, M_A,
           (i > 15) ? 4'd15 : 4'(i), 4'd0);
    end
    idle("sat_hold", 1'b1, C_N, 4'd15, 4'd0);

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      if (exp_q.size() > 0) begin
        nfail++;
        $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
